traffic_light_controller_param: RTL

Parametrised successor to the fixed-cycle junction controller. Drives the same four signal heads (main M1, main M2, main-turn MT, side S) through a protected-turn cycle. Adds:
- Per-phase durations set by parameter, counted in prescaled ticks.
- Demand-driven side/pedestrian phase, with request latching.
- All-red clearance intervals.
- Night flashing mode and a run/pause enable.

It sits between the junction's sensor/pushbutton inputs and the lamp drivers.

---
 rtl/traffic_light_controller_param.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_controller_param.sv
// rtl/traffic_light_controller_param.sv - parametrised protected-turn junction controller
//
// Sequences main (M1, M2), main-turn (MT) and side (S) signal heads through
// MG -> M2Y -> TG -> TY -> AR1 -> [SG -> SY -> AR2] -> MG, with per-phase
// durations counted in prescaled ticks, a latched side/pedestrian demand,
// all-red clearances, a night flashing mode and a run/pause enable.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   en                  1 = run, 0 = freeze prescaler, phase counter and state
//   night_mode          request flashing mode (taken at end of AR1/AR2)
//   side_req, ped_req   side-road sensor / pedestrian button, latched as demand
//   light_M1/M2/MT/S    lamp codes: 100 red, 010 yellow, 001 green, 000 dark
//   phase               current state code
//   ped_walk            walk signal, high during SG
module traffic_light_controller_param #(
    parameter int TICK_DIV       = 1,
    parameter int CNT_W          = 8,
    parameter int T_MG           = 7,
    parameter int T_Y            = 2,
    parameter int T_TG           = 5,
    parameter int T_SG           = 3,
    parameter int T_AR           = 1,
    parameter int SIDE_ON_DEMAND = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       night_mode,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] phase,
    output logic       ped_walk
);

    // Zero-valued parameters are promoted to 1.
    localparam int TD   = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int D_MG = (T_MG < 1) ? 1 : T_MG;
    localparam int D_Y  = (T_Y  < 1) ? 1 : T_Y;
    localparam int D_TG = (T_TG < 1) ? 1 : T_TG;
    localparam int D_SG = (T_SG < 1) ? 1 : T_SG;
    localparam int D_AR = (T_AR < 1) ? 1 : T_AR;
    localparam int PW   = (TD > 1) ? $clog2(TD) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TD - 1);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [3:0] {
        S_MG    = 4'd0,
        S_M2Y   = 4'd1,
        S_TG    = 4'd2,
        S_TY    = 4'd3,
        S_AR1   = 4'd4,
        S_SG    = 4'd5,
        S_SY    = 4'd6,
        S_AR2   = 4'd7,
        S_FLASH = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              demand_q, demand_d;
    logic              flash_q, flash_d;

    logic              tick;
    logic              legal;
    logic [CNT_W-1:0]  last_cnt;
    state_e            nxt_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_MG;
            cnt_q    <= '0;
            presc_q  <= '0;
            demand_q <= 1'b0;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            demand_q <= demand_d;
            flash_q  <= flash_d;
        end
    end

    // Per-state duration and successor; FLASH exits on night_mode alone.
    always_comb begin
        legal    = 1'b1;
        last_cnt = '0;
        nxt_seq  = S_AR2;
        case (state_q)
            S_MG:  begin last_cnt = CNT_W'(D_MG - 1); nxt_seq = S_M2Y; end
            S_M2Y: begin last_cnt = CNT_W'(D_Y - 1);  nxt_seq = S_TG;  end
            S_TG:  begin last_cnt = CNT_W'(D_TG - 1); nxt_seq = S_TY;  end
            S_TY:  begin last_cnt = CNT_W'(D_Y - 1);  nxt_seq = S_AR1; end
            S_AR1: begin
                last_cnt = CNT_W'(D_AR - 1);
                if (night_mode)
                    nxt_seq = S_FLASH;
                else if ((SIDE_ON_DEMAND == 0) || demand_q)
                    nxt_seq = S_SG;
                else
                    nxt_seq = S_MG;
            end
            S_SG:  begin last_cnt = CNT_W'(D_SG - 1); nxt_seq = S_SY;  end
            S_SY:  begin last_cnt = CNT_W'(D_Y - 1);  nxt_seq = S_AR2; end
            S_AR2: begin
                last_cnt = CNT_W'(D_AR - 1);
                nxt_seq  = night_mode ? S_FLASH : S_MG;
            end
            S_FLASH: begin last_cnt = '0; nxt_seq = S_AR2; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        flash_d  = flash_q;
        demand_d = demand_q;

        tick = en && (presc_q == PRESC_LAST);

        if (en)
            presc_d = tick ? '0 : presc_q + PW'(1);

        if (en && !legal) begin
            // Corrupted state code: recover through an all-red clearance.
            state_d = S_AR2;
            cnt_d   = '0;
            flash_d = 1'b0;
        end else if (tick) begin
            if (state_q == S_FLASH) begin
                if (!night_mode) begin
                    state_d = S_AR2;
                    flash_d = 1'b0;
                end else begin
                    flash_d = ~flash_q;
                end
            end else if (cnt_q == last_cnt) begin
                state_d = nxt_seq;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Clear on SG entry first so a request in the same cycle survives.
        if ((state_d == S_SG) && (state_q != S_SG))
            demand_d = 1'b0;
        if (side_req || ped_req)
            demand_d = 1'b1;
    end

    assign phase = state_q;

    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        ped_walk = 1'b0;
        case (state_q)
            S_MG:  begin light_M1 = GRN; light_M2 = GRN; end
            S_M2Y: begin light_M1 = GRN; light_M2 = YEL; end
            S_TG:  begin light_M1 = GRN; light_MT = GRN; end
            S_TY:  begin light_M1 = YEL; light_MT = YEL; end
            S_SG:  begin light_S  = GRN; ped_walk = 1'b1; end
            S_SY:  light_S = YEL;
            S_FLASH: begin
                light_M1 = flash_q ? YEL : DARK;
                light_M2 = flash_q ? YEL : DARK;
                light_MT = flash_q ? YEL : DARK;
                light_S  = flash_q ? RED : DARK;
            end
            default: ;
        endcase
    end

endmodule
